conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
- Hardware sequencer that drives the 34-bit core instruction bus for one full 3x3 convolution layer. It replaces bench-driven stimulus.
- Per kernel position kij it runs: weight fill to L0, weight load to the PE array, activation fill, execute, then OFIFO drain to psum memory.
- After all kij passes it runs output-stationary accumulation: for each output pixel it reads len_kij psums and accumulates them through the SFP.
- Sits beside the core; activations and weights are pre-written to xmem by the host.

Parameters:
col, 8, PE array columns; weight rows per kij
row, 8, PE array rows
in_w, 8, input feature-map width (square); len_nij = in_w*in_w
k_w, 3, kernel width; len_kij = k_w*k_w; out_w = in_w-k_w+1; len_onij = out_w*out_w
w_base, 1024, xmem base address of weights; kij block at w_base + kij*col
gap, 10, idle cycles after weight load and after execute

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a layer when idle
ofifo_valid  in  1  core OFIFO holds a full output row
inst  out  34  core instruction: [33]acc [32]CEN_pmem [31]WEN_pmem [30:20]A_pmem [19]CEN_xmem [18]WEN_xmem [17:7]A_xmem [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
sfp_clr  out  1  one-cycle clear of the SFP accumulator before each output pixel
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the layer completes
kij_idx  out  4  current kernel position
onij_idx  out  6  current output pixel during accumulation
acc_out_valid  out  1  one-cycle strobe: sfp_out holds the final value for onij_idx

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert) and IDLE values:
  - inst = INST_IDLE = 34'h1_800C_0000 (both CEN=1, both WEN=1, all else 0).
  - sfp_clr, busy, done, acc_out_valid, kij_idx and onij_idx are all 0.
- Reset mid-operation aborts immediately to IDLE; no partial completion is signalled.
- start is accepted only in IDLE; it is ignored while busy.
- ififo_wr and ififo_rd are always 0.
- Memory read latency is 1 cycle, so every consumer strobe lags its read by one cycle.
- States and per-pass behaviour (t counts from 0 within each state):
  - WFILL, col+1 cycles. Cycles t<col: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+kij*col+t. Cycles t>=1: l0_wr=1.
  - WLOAD, 2*col cycles: l0_rd=1, load=1.
  - WGAP, gap cycles: INST_IDLE.
  - XFILL, len_nij+1 cycles: same pattern as WFILL with A_xmem=t, t<len_nij.
  - EXEC, len_nij cycles: l0_rd=1, execute=1.
  - XGAP, gap cycles.
  - DRAIN: hold INST_IDLE until ofifo_valid=1; no timeout.
  - PWR, len_nij+1 cycles. Cycles t<len_nij: ofifo_rd=1. Cycles t>=1: CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+(t-1).
  - NEXTK, 1 cycle: if kij<len_kij-1, increment kij and go to WFILL; else clear kij and go to ACLR.
- Accumulation states, repeated for each onij:
  - ACLR, 1 cycle: sfp_clr=1.
  - ARD, len_kij+1 cycles. Cycles j<len_kij: CEN_pmem=0, WEN_pmem=1, A_pmem=addr(onij,j). Cycles j>=1: acc=1.
  - AOUT, 1 cycle: acc_out_valid=1. If onij<len_onij-1, increment onij and go to ACLR; else go to FIN.
  - FIN: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Address generation:
  - addr(onij,kij) = kij*len_nij + (onij/out_w + kij/k_w)*in_w + onij%out_w + kij%k_w.
  - Computed as 11-bit unsigned; no modulo or wrap is permitted.
  - Elaboration-time assertion: len_kij*len_nij <= 2048, and w_base + len_kij*col <= 2048.
- Division and modulo are implemented with row/column counters, not dividers.

Optional Feature:
- Macro: CONV_SEQ_CTRL_PERF_EN.
- Defined: adds output port perf_cycles, 32 bits.
  - Clears on an accepted start and increments every busy cycle.
  - Freezes at done and holds until the next start.
  - Also adds output drain_stall, 16 bits: total cycles spent in DRAIN.
  - Both are 0 at reset.
- Undefined: neither port exists; no counters are synthesized.

Decomposition:
- Package conv_seq_ctrl_pkg holds:
  - State enum: IDLE, WFILL, WLOAD, WGAP, XFILL, EXEC, XGAP, DRAIN, PWR, NEXTK, ACLR, ARD, AOUT, FIN.
  - Inst bit-position localparams and INST_IDLE.
- Sub-module acc_addr_gen:
  - Maintains o_row/o_col and ki/kj counters.
  - Emits addr(onij,kij) registered, aligned to ARD cycle j.

Test Plan:
- Reset and start: hold reset=0 then release → inst=34'h1_800C_0000 and busy=0; start pulse → busy=1 next cycle; a second start while busy changes nothing.
- kij=0 pass with ofifo_valid tied 1:
  - A_xmem sequence is 1024..1031 with l0_wr lagging by 1.
  - load is high for exactly 16 cycles.
  - execute is high for 64 cycles.
  - PWR writes A_pmem 0..63 with WEN_pmem=0.
- kij=5: WFILL reads A_xmem 1064..1071; PWR writes 320..383.
- DRAIN stall: hold ofifo_valid=0 for 37 cycles → controller stays in DRAIN with INST_IDLE; ofifo_rd asserts the cycle after ofifo_valid rises.
- Accumulation addresses:
  - onij=0: ARD reads 0, 65, 130, 200, 265, 330, 400, 465, 530; acc high for 9 cycles; acc_out_valid one cycle later.
  - onij=35, kij=8: reads A_pmem=575.
  - Exactly 36 acc_out_valid strobes are produced, followed by done.
- Reset mid-EXEC: assert reset → inst returns to INST_IDLE asynchronously, with no done pulse; a new start reruns from kij=0.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and instruction-bus field positions for the conv_seq_ctrl sequencer.
package conv_seq_ctrl_pkg;

    localparam int unsigned INST_W = 34;
    localparam int unsigned AW     = 11;

    localparam int unsigned B_ACC      = 33;
    localparam int unsigned B_CEN_PMEM = 32;
    localparam int unsigned B_WEN_PMEM = 31;
    localparam int unsigned B_A_PMEM   = 20;
    localparam int unsigned B_CEN_XMEM = 19;
    localparam int unsigned B_WEN_XMEM = 18;
    localparam int unsigned B_A_XMEM   = 7;
    localparam int unsigned B_OFIFO_RD = 6;
    localparam int unsigned B_IFIFO_WR = 5;
    localparam int unsigned B_IFIFO_RD = 4;
    localparam int unsigned B_L0_RD    = 3;
    localparam int unsigned B_L0_WR    = 2;
    localparam int unsigned B_EXECUTE  = 1;
    localparam int unsigned B_LOAD     = 0;

    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        IDLE, WFILL, WLOAD, WGAP, XFILL, EXEC, XGAP, DRAIN,
        PWR, NEXTK, ACLR, ARD, AOUT, FIN
    } state_e;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Core-facing bus of the sequencer: instruction word, SFP controls and OFIFO status.
interface conv_seq_ctrl_if;
    import conv_seq_ctrl_pkg::*;

    logic [INST_W-1:0] inst;
    logic              ofifo_valid;
    logic              sfp_clr;
    logic              acc_out_valid;

    modport master (output inst, output sfp_clr, output acc_out_valid, input ofifo_valid);
    modport slave  (input inst, input sfp_clr, input acc_out_valid, output ofifo_valid);
endinterface

// File: rtl/conv_seq_ctrl_acc_addr_gen.sv
// Psum read-address generator for output-stationary accumulation; addr holds the
// address for the next ARD read and advances on step, with row/column counters in place of div/mod.
module acc_addr_gen
    import conv_seq_ctrl_pkg::*;
#(
    parameter int unsigned in_w = 8,
    parameter int unsigned k_w  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    input  logic          next_pix,
    output logic [AW-1:0] addr
);
    localparam int unsigned CW      = 8;
    localparam int unsigned OUT_W   = in_w - k_w + 1;
    localparam int unsigned LEN_NIJ = in_w * in_w;
    localparam logic [CW-1:0] K_LAST  = CW'(k_w - 1);
    localparam logic [CW-1:0] O_LAST  = CW'(OUT_W - 1);
    localparam logic [AW-1:0] INC_KJ  = AW'(LEN_NIJ + 1);
    localparam logic [AW-1:0] INC_KI  = AW'(LEN_NIJ + OUT_W);
    localparam logic [AW-1:0] INC_ROW = AW'(k_w);

    logic [CW-1:0] ki_q, ki_d, kj_q, kj_d, o_col_q, o_col_d, o_row_q, o_row_d;
    logic [AW-1:0] pix_q, pix_d, addr_q, addr_d;

    always_comb begin
        ki_d    = ki_q;
        kj_d    = kj_q;
        o_col_d = o_col_q;
        o_row_d = o_row_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        if (clr) begin
            ki_d    = '0;
            kj_d    = '0;
            o_col_d = '0;
            o_row_d = '0;
            pix_d   = '0;
            addr_d  = '0;
        end else if (next_pix && !(o_row_q == O_LAST && o_col_q == O_LAST)) begin
            ki_d = '0;
            kj_d = '0;
            if (o_col_q == O_LAST) begin
                o_col_d = '0;
                o_row_d = o_row_q + CW'(1);
                pix_d   = pix_q + INC_ROW;
            end else begin
                o_col_d = o_col_q + CW'(1);
                pix_d   = pix_q + AW'(1);
            end
            addr_d = pix_d;
        end else if (step) begin
            // the final kernel step leaves addr untouched so it never runs past the psum space
            if (kj_q != K_LAST) begin
                kj_d   = kj_q + CW'(1);
                addr_d = addr_q + INC_KJ;
            end else begin
                kj_d = '0;
                if (ki_q != K_LAST) begin
                    ki_d   = ki_q + CW'(1);
                    addr_d = addr_q + INC_KI;
                end else begin
                    ki_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ki_q    <= '0;
            kj_q    <= '0;
            o_col_q <= '0;
            o_row_q <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
        end else begin
            ki_q    <= ki_d;
            kj_q    <= kj_d;
            o_col_q <= o_col_d;
            o_row_q <= o_row_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
        end
    end

    assign addr = addr_q;
endmodule

// File: rtl/conv_seq_ctrl.sv
// Instruction-bus sequencer for one 3x3 convolution layer with output-stationary accumulation.
// Optional CONV_SEQ_CTRL_PERF_EN adds perf_cycles / drain_stall counters.
module conv_seq_ctrl
    import conv_seq_ctrl_pkg::*;
#(
    parameter int unsigned col    = 8,
    parameter int unsigned row    = 8,
    parameter int unsigned in_w   = 8,
    parameter int unsigned k_w    = 3,
    parameter int unsigned w_base = 1024,
    parameter int unsigned gap    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    conv_seq_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic [3:0]       kij_idx,
    output logic [5:0]       onij_idx
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [15:0]      drain_stall
`endif
);
    localparam int unsigned LEN_NIJ  = in_w * in_w;
    localparam int unsigned LEN_KIJ  = k_w * k_w;
    localparam int unsigned OUT_W    = in_w - k_w + 1;
    localparam int unsigned LEN_ONIJ = OUT_W * OUT_W;
    localparam int unsigned TW       = 16;

    localparam logic [TW-1:0] T_WFILL = TW'(col);
    localparam logic [TW-1:0] T_WLOAD = TW'(2 * col - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(gap - 1);
    localparam logic [TW-1:0] T_NIJ   = TW'(LEN_NIJ);
    localparam logic [TW-1:0] T_EXEC  = TW'(LEN_NIJ - 1);
    localparam logic [TW-1:0] T_KIJ   = TW'(LEN_KIJ);
    localparam logic [3:0]    KIJ_LAST  = 4'(LEN_KIJ - 1);
    localparam logic [5:0]    ONIJ_LAST = 6'(LEN_ONIJ - 1);
    localparam logic [AW-1:0] W_BASE    = AW'(w_base);

    if (LEN_KIJ * LEN_NIJ > 2048 || w_base + LEN_KIJ * col > 2048) begin : g_addr_err
        $error("conv_seq_ctrl: memory footprint exceeds 11-bit address space");
    end
    if (row == 0) begin : g_row_err
        $error("conv_seq_ctrl: row must be non-zero");
    end

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [3:0]        kij_q, kij_d;
    logic [5:0]        onij_q, onij_d;
    logic [AW-1:0]     waddr_q, waddr_d, paddr_q, paddr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              sfp_clr_q, sfp_clr_d, aov_q, aov_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              ag_clr, ag_step, ag_next;
    logic [AW-1:0]     ag_addr;

    acc_addr_gen #(.in_w(in_w), .k_w(k_w)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (ag_clr),
        .step     (ag_step),
        .next_pix (ag_next),
        .addr     (ag_addr)
    );

    // Outputs are a function of the next state, so each registered output lines up with its state.
    always_comb begin
        state_d = state_q;
        t_d     = t_q + TW'(1);
        kij_d   = kij_q;
        onij_d  = onij_q;
        ag_clr  = 1'b0;
        ag_next = 1'b0;
        case (state_q)
            IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d = WFILL;
                    ag_clr  = 1'b1;
                end
            end
            WFILL: if (t_q == T_WFILL) begin state_d = WLOAD; t_d = '0; end
            WLOAD: if (t_q == T_WLOAD) begin state_d = WGAP;  t_d = '0; end
            WGAP:  if (t_q == T_GAP)   begin state_d = XFILL; t_d = '0; end
            XFILL: if (t_q == T_NIJ)   begin state_d = EXEC;  t_d = '0; end
            EXEC:  if (t_q == T_EXEC)  begin state_d = XGAP;  t_d = '0; end
            XGAP:  if (t_q == T_GAP)   begin state_d = DRAIN; t_d = '0; end
            DRAIN: begin
                t_d = '0;
                if (bus.ofifo_valid) state_d = PWR;
            end
            PWR:   if (t_q == T_NIJ)   begin state_d = NEXTK; t_d = '0; end
            NEXTK: begin
                t_d = '0;
                if (kij_q == KIJ_LAST) begin
                    kij_d   = '0;
                    state_d = ACLR;
                end else begin
                    kij_d   = kij_q + 4'd1;
                    state_d = WFILL;
                end
            end
            ACLR: begin t_d = '0; state_d = ARD; end
            ARD:   if (t_q == T_KIJ)   begin state_d = AOUT; t_d = '0; end
            AOUT: begin
                t_d = '0;
                if (onij_q == ONIJ_LAST) begin
                    onij_d  = '0;
                    state_d = FIN;
                end else begin
                    onij_d  = onij_q + 6'd1;
                    ag_next = 1'b1;
                    state_d = ACLR;
                end
            end
            FIN:     begin t_d = '0; state_d = IDLE; end
            default: begin t_d = '0; state_d = IDLE; end
        endcase

        inst_d  = INST_IDLE;
        waddr_d = waddr_q;
        paddr_d = paddr_q;
        ag_step = 1'b0;
        case (state_d)
            WFILL: begin
                if (t_d < T_WFILL) begin
                    inst_d[B_CEN_XMEM]     = 1'b0;
                    inst_d[B_A_XMEM +: AW] = waddr_q;
                    waddr_d                = waddr_q + AW'(1);
                end
                if (t_d != '0) inst_d[B_L0_WR] = 1'b1;
            end
            WLOAD: begin
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_LOAD]  = 1'b1;
            end
            XFILL: begin
                if (t_d < T_NIJ) begin
                    inst_d[B_CEN_XMEM]     = 1'b0;
                    inst_d[B_A_XMEM +: AW] = t_d[AW-1:0];
                end
                if (t_d != '0) inst_d[B_L0_WR] = 1'b1;
            end
            EXEC: begin
                inst_d[B_L0_RD]   = 1'b1;
                inst_d[B_EXECUTE] = 1'b1;
            end
            PWR: begin
                if (t_d < T_NIJ) inst_d[B_OFIFO_RD] = 1'b1;
                if (t_d != '0) begin
                    inst_d[B_CEN_PMEM]     = 1'b0;
                    inst_d[B_WEN_PMEM]     = 1'b0;
                    inst_d[B_A_PMEM +: AW] = paddr_q;
                    paddr_d                = paddr_q + AW'(1);
                end
            end
            ARD: begin
                if (t_d < T_KIJ) begin
                    inst_d[B_CEN_PMEM]     = 1'b0;
                    inst_d[B_A_PMEM +: AW] = ag_addr;
                    ag_step                = 1'b1;
                end
                if (t_d != '0) inst_d[B_ACC] = 1'b1;
            end
            FIN: begin
                waddr_d = W_BASE;
                paddr_d = '0;
            end
            default: ;
        endcase

        sfp_clr_d = (state_d == ACLR);
        aov_d     = (state_d == AOUT);
        done_d    = (state_d == FIN);
        busy_d    = !(state_d inside {IDLE, FIN});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            kij_q     <= '0;
            onij_q    <= '0;
            waddr_q   <= W_BASE;
            paddr_q   <= '0;
            inst_q    <= INST_IDLE;
            sfp_clr_q <= 1'b0;
            aov_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            kij_q     <= kij_d;
            onij_q    <= onij_d;
            waddr_q   <= waddr_d;
            paddr_q   <= paddr_d;
            inst_q    <= inst_d;
            sfp_clr_q <= sfp_clr_d;
            aov_q     <= aov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.inst          = inst_q;
    assign bus.sfp_clr       = sfp_clr_q;
    assign bus.acc_out_valid = aov_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign kij_idx           = kij_q;
    assign onij_idx          = onij_q;

`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        perf_d  = perf_q;
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            perf_d  = '0;
            stall_d = '0;
        end else begin
            if (busy_q)            perf_d  = perf_q + 32'd1;
            if (state_q == DRAIN)  stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q  <= '0;
            stall_q <= '0;
        end else begin
            perf_q  <= perf_d;
            stall_q <= stall_d;
        end
    end

    assign perf_cycles = perf_q;
    assign drain_stall = stall_q;
`endif
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: full layer walk, DRAIN stall, accumulation addresses, mid-run reset.
module tb_conv_seq_ctrl;
    localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
    localparam int B_ACC = 33, B_CENP = 32, B_WENP = 31, B_AP = 20, B_CENX = 19;
    localparam int B_AX = 7, B_ORD = 6, B_L0WR = 2, B_EXE = 1, B_LOAD = 0;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done;
    logic [3:0] kij_idx;
    logic [5:0] onij_idx;
`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] drain_stall;
`endif

    conv_seq_ctrl_if bus ();

    conv_seq_ctrl #(.col(8), .row(8), .in_w(8), .k_w(3), .w_base(1024), .gap(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .kij_idx  (kij_idx),
        .onij_idx (onij_idx)
`ifdef CONV_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .drain_stall (drain_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int n, bad, aov_cnt;
    logic [33:0] e;
    int A0 [9] = '{0, 65, 130, 200, 265, 330, 400, 465, 530};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int amodel(input int o, input int k);
        return k * 64 + (o / 6 + k / 3) * 8 + o % 6 + k % 3;
    endfunction

    // Entered on the WFILL t=0 sample; leaves on the sample after NEXTK.
    task automatic run_pass(input int k, input int stall, input bit poke);
        logic [33:0] x;
        int m, b;
        check("kij_idx", 64'(kij_idx), 64'(k));
        check("wfill_a0", 64'(bus.inst[B_AX +: 11]), 64'(1024 + 8 * k));
        b = 0;
        for (int t = 0; t <= 8; t++) begin
            x = IDLE_I;
            if (t < 8) begin
                x[B_CENX] = 1'b0;
                x[B_AX +: 11] = 11'(1024 + 8 * k + t);
            end
            if (t >= 1) x[B_L0WR] = 1'b1;
            if (bus.inst !== x) b++;
            if (poke) start = (t == 2);
            tick;
        end
        check("wfill_seq", 64'(b), 64'd0);
        m = 0; b = 0;
        while (bus.inst[B_LOAD] === 1'b1 && m < 100) begin
            if (bus.inst !== (IDLE_I | 34'(9))) b++;
            m++;
            tick;
        end
        check("load_len", 64'(m), 64'd16);
        check("load_inst", 64'(b), 64'd0);
        m = 0;
        while (bus.inst === IDLE_I && m < 100) begin m++; tick; end
        check("wgap_len", 64'(m), 64'd10);
        b = 0;
        for (int t = 0; t <= 64; t++) begin
            x = IDLE_I;
            if (t < 64) begin
                x[B_CENX] = 1'b0;
                x[B_AX +: 11] = 11'(t);
            end
            if (t >= 1) x[B_L0WR] = 1'b1;
            if (bus.inst !== x) b++;
            tick;
        end
        check("xfill_seq", 64'(b), 64'd0);
        m = 0; b = 0;
        while (bus.inst[B_EXE] === 1'b1 && m < 200) begin
            if (bus.inst !== (IDLE_I | 34'(10))) b++;
            m++;
            tick;
        end
        check("exec_len", 64'(m), 64'd64);
        check("exec_inst", 64'(b), 64'd0);
        m = 0; b = 0;
        while (bus.inst[B_ORD] !== 1'b1 && m < 2000) begin
            if (bus.inst !== IDLE_I || busy !== 1'b1 || kij_idx !== 4'(k)) b++;
            m++;
            if (stall > 0 && m == 10 + stall) bus.ofifo_valid = 1'b1;
            tick;
        end
        check("drain_wait", 64'(m), 64'(stall > 0 ? 10 + stall : 11));
        check("drain_idle", 64'(b), 64'd0);
        b = 0;
        for (int t = 0; t <= 64; t++) begin
            x = IDLE_I;
            if (t < 64) x[B_ORD] = 1'b1;
            if (t >= 1) begin
                x[B_CENP] = 1'b0;
                x[B_WENP] = 1'b0;
                x[B_AP +: 11] = 11'(64 * k + t - 1);
            end
            if (t == 1)  check("pwr_a_first", 64'(bus.inst[B_AP +: 11]), 64'(64 * k));
            if (t == 64) check("pwr_a_last", 64'(bus.inst[B_AP +: 11]), 64'(64 * k + 63));
            if (bus.inst !== x) b++;
            tick;
        end
        check("pwr_seq", 64'(b), 64'd0);
        check("nextk_idle", 64'(bus.inst), 64'(IDLE_I));
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.ofifo_valid = 1'b1;
        repeat (3) tick;
        check("rst_inst", 64'(bus.inst), 64'(IDLE_I));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sfp_clr", 64'(bus.sfp_clr), 64'd0);
        check("rst_aov", 64'(bus.acc_out_valid), 64'd0);
        check("rst_kij", 64'(kij_idx), 64'd0);
        check("rst_onij", 64'(onij_idx), 64'd0);
        reset = 1'b1;
        repeat (2) tick;
        check("idle_inst", 64'(bus.inst), 64'(IDLE_I));
        check("idle_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 9; k++) begin
            if (k == 1) bus.ofifo_valid = 1'b0;
            run_pass(k, (k == 1) ? 37 : 0, k == 0);
        end

        aov_cnt = 0;
        bad = 0;
        for (int o = 0; o < 36; o++) begin
            if (bus.sfp_clr !== 1'b1 || bus.inst !== IDLE_I || onij_idx !== 6'(o)) bad++;
            if (bus.acc_out_valid === 1'b1) aov_cnt++;
            tick;
            for (int j = 0; j <= 9; j++) begin
                e = IDLE_I;
                if (j < 9) begin
                    e[B_CENP] = 1'b0;
                    e[B_AP +: 11] = 11'(amodel(o, j));
                end
                if (j >= 1) e[B_ACC] = 1'b1;
                if (o == 0 && j < 9) check("acc0_addr", 64'(bus.inst[B_AP +: 11]), 64'(A0[j]));
                if (o == 35 && j == 8) check("acc35_k8", 64'(bus.inst[B_AP +: 11]), 64'd575);
                if (bus.inst !== e || bus.sfp_clr !== 1'b0) bad++;
                if (bus.acc_out_valid === 1'b1) aov_cnt++;
                tick;
            end
            if (bus.acc_out_valid === 1'b1) aov_cnt++;
            if (bus.acc_out_valid !== 1'b1 || bus.inst !== IDLE_I || onij_idx !== 6'(o)) bad++;
            tick;
        end
        check("acc_seq", 64'(bad), 64'd0);
        check("aov_count", 64'(aov_cnt), 64'd36);
        check("fin_done", 64'(done), 64'd1);
        check("fin_busy", 64'(busy), 64'd0);
        tick;
        check("post_done", 64'(done), 64'd0);
        check("post_inst", 64'(bus.inst), 64'(IDLE_I));

        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (bus.inst[B_EXE] !== 1'b1 && n < 500) begin n++; tick; end
        check("reach_exec", 64'(bus.inst[B_EXE]), 64'd1);
        repeat (5) tick;
        reset = 1'b0;
        #1;
        check("rst_async_inst", 64'(bus.inst), 64'(IDLE_I));
        check("rst_async_busy", 64'(busy), 64'd0);
        bad = 0;
        repeat (3) begin
            tick;
            if (done !== 1'b0) bad++;
        end
        reset = 1'b1;
        repeat (3) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_no_done", 64'(bad), 64'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        run_pass(0, 0, 1'b0);
        check("restart_kij1", 64'(kij_idx), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
